cfork3_sync_mmu: RTL and testbench
==================================

# cfork3_sync_mmu

Clocked one-to-three fork for the MMU drive/free handshake. It is the split-side counterpart of the three-way wait-merge join. One upstream transaction (a drive pulse plus payload) is broadcast to three downstream consumers. The upstream free is returned only after every consumer has freed. It sits between a single MMU request producer and three parallel consumers (TLB lookup, PTW, permission check) in the synchronous island.

## Interface
- `DATA_W`, 32, payload width.
- `TIMEOUT_CYC`, 255, watchdog limit in WAIT cycles (used only with `FORK_TIMEOUT_EN`, 1..65535).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_drive`  in  1  upstream request pulse (single cycle).
- `i_data`  in  DATA_W  payload, sampled with `i_drive`.
- `o_free`  out  1  upstream completion pulse (single cycle).
- `o_drive0/1/2`  out  1  downstream request pulses.
- `o_data`  out  DATA_W  latched payload, shared by all ports.
- `i_freeNext0/1/2`  in  1  downstream completion pulses.
- `o_proto_err`  out  1  sticky: free with nothing outstanding, or drive while busy.
- `o_timeout`  out  1  sticky watchdog flag (tied 0 without the macro).

## Operation
- States:
  - IDLE: waiting for `i_drive`.
  - ISSUE: broadcasting the request.
  - WAIT: collecting frees.
  - RELEASE: returning the upstream free.
- IDLE + `i_drive` → latch `i_data` into `o_data`, clear done mask, go to ISSUE.
- ISSUE: pulse `o_drive0..2` together for one cycle, go to WAIT. Frees are sampled from this cycle on.
- WAIT / ISSUE: done mask |= {`i_freeNext2`, `i_freeNext1`, `i_freeNext0`}.
  - When (mask | current frees) == 3'b111, go to RELEASE next cycle.
  - Frees may arrive in any order, and simultaneously.
- RELEASE: `o_free`=1 for one cycle, then IDLE.
  - `i_drive` in the RELEASE cycle is accepted exactly as in IDLE (back-to-back), going straight to ISSUE.
- `o_data` holds stable from capture until the next accepted `i_drive`.
- Errors (sticky, cleared only by `rst`):
  - `i_drive` in ISSUE or WAIT is dropped and sets `o_proto_err`.
  - `i_freeNextK` with bit K already set, or arriving in IDLE/RELEASE, is ignored and sets `o_proto_err`.
- Reset mid-transaction: state → IDLE and mask → 0 immediately. Outstanding consumer frees that arrive later raise `o_proto_err`.

## Timing
- Reset values:
  - All `o_drive*` = 0, `o_free` = 0.
  - `o_data` = 0.
  - `o_proto_err` = 0, `o_timeout` = 0.
  - State = IDLE, mask = 0, watchdog counter = 0.
- Latency:
  - `i_drive` at cycle T → `o_drive*` at T+1.
  - Last free at cycle F (F ≥ T+1) → `o_free` at F+1.
  - Minimum round trip is T→T+2. Peak throughput is one transaction per 2 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `FORK_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYC` with the mask incomplete: set `o_timeout`, force RELEASE (`o_free` pulses), clear the mask.
  - Late frees from timed-out ports then raise `o_proto_err`.
- Undefined: no counter is built, `o_timeout` is tied to 0, and WAIT is unbounded.

## Structure
- Package `mmu_fork_pkg`:
  - State enum `fork_state_e` (IDLE, ISSUE, WAIT, RELEASE).
  - `FORK_PORTS` = 3.
  - Watchdog counter width `FORK_WDOG_W` = 16.
- Sub-module `fork_ack_collect_mmu` (one instance): done-mask register, duplicate-free detection, `all_done` output. The top holds the FSM, payload register, error flags and watchdog.

## Test plan
- Reset, then `i_drive`=1 with `i_data`=32'hA5A5_0001 at T:
  - `o_drive0..2` pulse at T+1 with `o_data`=32'hA5A5_0001.
  - Frees on all ports at T+1 → `o_free` at T+2.
- Staggered frees at T+3 (port 2), T+5 (port 0), T+9 (port 1) → single `o_free` pulse at T+10, none earlier.
- Back-to-back transactions: second `i_drive` with data 32'h0000_0002 in the RELEASE cycle → accepted, new `o_drive*` next cycle, `o_proto_err` stays 0.
- `i_drive` during WAIT, and a duplicate `i_freeNext0` → both ignored, `o_proto_err`=1, transaction completes normally.
- Macro on, `TIMEOUT_CYC`=8, port 1 never frees → `o_timeout`=1 and `o_free` pulse 8 cycles after entering WAIT. A later `i_freeNext1` → `o_proto_err`=1.
- Assert `rst` in WAIT with mask 3'b011 → all outputs return to reset values, and the next `i_drive` starts a clean transaction.

Source files
------------

// File: rtl/cfork3_sync_mmu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mmu_fork_pkg : shared types/constants for the MMU 1-to-3 fork      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mmu_fork_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } fork_state_e;

  localparam int FORK_PORTS  = 3;
  localparam int FORK_WDOG_W = 16;

endpackage
`default_nettype wire

// File: rtl/cfork3_sync_mmu_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cfork3_sync_mmu_if : drive/free bundle between producer and fork   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface cfork3_sync_mmu_if #(
  parameter int DATA_W = 32
) ();

  logic              i_drive;
  logic [DATA_W-1:0] i_data;
  logic              o_free;
  logic              o_drive0;
  logic              o_drive1;
  logic              o_drive2;
  logic [DATA_W-1:0] o_data;
  logic              i_freeNext0;
  logic              i_freeNext1;
  logic              i_freeNext2;

  // Fork side
  modport slave (
    input  i_drive, i_data, i_freeNext0, i_freeNext1, i_freeNext2,
    output o_free, o_drive0, o_drive1, o_drive2, o_data
  );

  // Producer/consumer side
  modport master (
    output i_drive, i_data, i_freeNext0, i_freeNext1, i_freeNext2,
    input  o_free, o_drive0, o_drive1, o_drive2, o_data
  );

endinterface
`default_nettype wire

// File: rtl/cfork3_sync_mmu_ack_collect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fork_ack_collect_mmu : done-mask of consumer frees, dup detection  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fork_ack_collect_mmu
  import mmu_fork_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [FORK_PORTS-1:0] i_free,
  output logic                  o_all_done,
  output logic                  o_dup_err
);

  logic [FORK_PORTS-1:0] mask_q;
  logic [FORK_PORTS-1:0] mask_d;

  always_comb begin
    mask_d = mask_q;
    if (i_clr) begin
      mask_d = '0;
    end else if (i_en) begin
      mask_d = mask_q | i_free;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  // Current-cycle frees count toward completion so the last free releases next cycle
  assign o_all_done = i_en && ((mask_q | i_free) == {FORK_PORTS{1'b1}});
  assign o_dup_err  = i_en && (|(mask_q & i_free));

endmodule
`default_nettype wire

// File: rtl/cfork3_sync_mmu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cfork3_sync_mmu : clocked 1-to-3 drive/free fork for the MMU path  |
// | Optional watchdog: define FORK_TIMEOUT_EN.  Rev 1.0                |
// +--------------------------------------------------------------------+
module cfork3_sync_mmu
  import mmu_fork_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  cfork3_sync_mmu_if.slave  bus,
  output logic              o_proto_err,
  output logic              o_timeout
);

  fork_state_e           state_q, state_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  drive_q, drive_d;
  logic                  free_q, free_d;
  logic                  proto_err_q, proto_err_d;

  logic [FORK_PORTS-1:0] w_frees;
  logic                  w_collect;
  logic                  w_accept;
  logic                  w_all_done;
  logic                  w_dup_err;
  logic                  w_expire;
  logic                  w_mask_clr;

  assign w_frees    = {bus.i_freeNext2, bus.i_freeNext1, bus.i_freeNext0};
  assign w_collect  = (state_q == ISSUE) || (state_q == WAIT);
  assign w_mask_clr = w_accept || (state_d == RELEASE);

  fork_ack_collect_mmu u_ack (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_collect),
    .i_clr      (w_mask_clr),
    .i_free     (w_frees),
    .o_all_done (w_all_done),
    .o_dup_err  (w_dup_err)
  );

  always_comb begin
    state_d  = state_q;
    drive_d  = 1'b0;
    w_accept = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        if (bus.i_drive) begin
          w_accept = 1'b1;
          drive_d  = 1'b1;
          state_d  = ISSUE;
        end else begin
          state_d  = IDLE;
        end
      end
      ISSUE:   state_d = w_all_done ? RELEASE : WAIT;
      WAIT:    if (w_all_done || w_expire) state_d = RELEASE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    free_d      = (state_d == RELEASE);
    data_d      = w_accept ? bus.i_data : data_q;
    proto_err_d = proto_err_q
                | (bus.i_drive && w_collect)
                | w_dup_err
                | ((|w_frees) && !w_collect);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      drive_q     <= 1'b0;
      free_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      drive_q     <= drive_d;
      free_q      <= free_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef FORK_TIMEOUT_EN
  localparam logic [FORK_WDOG_W-1:0] TIMEOUT_LIM = FORK_WDOG_W'(TIMEOUT_CYC);

  logic [FORK_WDOG_W-1:0] wdog_q, wdog_d;
  logic                   timeout_q, timeout_d;

  // Counter value k means this is the (k+1)-th WAIT cycle
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == WAIT) begin
      wdog_d = wdog_q + 1'b1;
    end else if (state_d == WAIT) begin
      wdog_d = '0;
    end
    timeout_d = timeout_q | (w_expire && !w_all_done);
  end

  assign w_expire = (state_q == WAIT) && ((wdog_q + 1'b1) == TIMEOUT_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |FORK_WDOG_W'(TIMEOUT_CYC);
  assign w_expire  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign bus.o_drive0 = drive_q;
  assign bus.o_drive1 = drive_q;
  assign bus.o_drive2 = drive_q;
  assign bus.o_free   = free_q;
  assign bus.o_data   = data_q;
  assign o_proto_err  = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cfork3_sync_mmu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cfork3_sync_mmu : directed self-checking bench for the fork     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_cfork3_sync_mmu;

  logic clk = 1'b0;
  logic rst;
  logic o_proto_err;
  logic o_timeout;
  int   tests = 0;
  int   fails = 0;

  cfork3_sync_mmu_if #(.DATA_W(32)) bus ();

  cfork3_sync_mmu #(.DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_proto_err (o_proto_err),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] drv, input logic fr,
                         input logic [31:0] dat);
    chk({tag, "_drv"},  32'({bus.o_drive2, bus.o_drive1, bus.o_drive0}), 32'(drv));
    chk({tag, "_free"}, 32'(bus.o_free), 32'(fr));
    chk({tag, "_data"}, bus.o_data, dat);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frees(input logic [2:0] f);
    bus.i_freeNext0 = f[0];
    bus.i_freeNext1 = f[1];
    bus.i_freeNext2 = f[2];
  endtask

  // One-cycle drive; afterwards the bus holds junk data to prove o_data is latched
  task automatic drive(input logic [31:0] d);
    bus.i_drive = 1'b1;
    bus.i_data  = d;
    step();
    bus.i_drive = 1'b0;
    bus.i_data  = 32'hDEAD_BEEF;
  endtask

  initial begin
    rst         = 1'b0;
    bus.i_drive = 1'b0;
    bus.i_data  = '0;
    set_frees(3'b000);
    #2 rst = 1'b1;
    step();
    step();
    chk_out("reset", 3'b000, 1'b0, 32'h0);
    chk("reset_perr", 32'(o_proto_err), 32'h0);
    chk("reset_tmo",  32'(o_timeout),   32'h0);
    rst = 1'b0;

    // Simultaneous frees in the ISSUE cycle
    drive(32'hA5A5_0001);
    chk_out("t1_issue", 3'b111, 1'b0, 32'hA5A5_0001);
    set_frees(3'b111);
    step();
    set_frees(3'b000);
    chk_out("t1_rel", 3'b000, 1'b1, 32'hA5A5_0001);
    step();
    chk_out("t1_idle", 3'b000, 1'b0, 32'hA5A5_0001);

    // Staggered frees: port2 @T+3, port0 @T+5, port1 @T+9 -> o_free only @T+10
    drive(32'h0000_0003);
    chk_out("t2_issue", 3'b111, 1'b0, 32'h0000_0003);
    for (int c = 1; c <= 10; c++) begin
      set_frees(c == 3 ? 3'b100 : c == 5 ? 3'b001 : c == 9 ? 3'b010 : 3'b000);
      step();
      chk("t2_free", 32'(bus.o_free), 32'(c + 1 == 10));
    end
    set_frees(3'b000);
    chk("t2_perr", 32'(o_proto_err), 32'h0);

    // Back-to-back: new drive in the RELEASE cycle
    drive(32'h0000_0010);
    set_frees(3'b111);
    step();
    set_frees(3'b000);
    chk("t3_rel1", 32'(bus.o_free), 32'h1);
    bus.i_drive = 1'b1;
    bus.i_data  = 32'h0000_0002;
    step();
    bus.i_drive = 1'b0;
    chk_out("t3_b2b", 3'b111, 1'b0, 32'h0000_0002);
    chk("t3_perr_a", 32'(o_proto_err), 32'h0);
    set_frees(3'b111);
    step();
    set_frees(3'b000);
    chk("t3_rel2", 32'(bus.o_free), 32'h1);
    step();
    chk("t3_perr_b", 32'(o_proto_err), 32'h0);

    // Drive during WAIT is dropped and flagged
    drive(32'h0000_0044);
    set_frees(3'b001);
    step();
    set_frees(3'b000);
    bus.i_drive = 1'b1;
    bus.i_data  = 32'h0000_0BAD;
    step();
    bus.i_drive = 1'b0;
    chk("t4_perr", 32'(o_proto_err), 32'h1);
    chk_out("t4_drop", 3'b000, 1'b0, 32'h0000_0044);
    set_frees(3'b110);
    step();
    set_frees(3'b000);
    chk_out("t4_done", 3'b000, 1'b1, 32'h0000_0044);
    step();

    // Async reset in WAIT with mask 3'b011
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_perr_clr", 32'(o_proto_err), 32'h0);
    drive(32'h0000_0066);
    set_frees(3'b011);
    step();
    set_frees(3'b000);
    step();
    #2 rst = 1'b1;
    #1;
    chk_out("r_async", 3'b000, 1'b0, 32'h0);
    chk("r_perr", 32'(o_proto_err), 32'h0);
    chk("r_tmo",  32'(o_timeout),   32'h0);
    step();
    rst = 1'b0;
    drive(32'h0000_0077);
    chk_out("r_clean", 3'b111, 1'b0, 32'h0000_0077);
    set_frees(3'b111);
    step();
    set_frees(3'b000);
    chk_out("r_rel", 3'b000, 1'b1, 32'h0000_0077);
    step();
    chk("r_perr_b", 32'(o_proto_err), 32'h0);

    // Duplicate free on port 0
    drive(32'h0000_0088);
    set_frees(3'b001);
    step();
    set_frees(3'b000);
    chk("d_perr_a", 32'(o_proto_err), 32'h0);
    set_frees(3'b001);
    step();
    set_frees(3'b000);
    chk("d_perr_b", 32'(o_proto_err), 32'h1);
    chk("d_nofree", 32'(bus.o_free), 32'h0);
    set_frees(3'b110);
    step();
    set_frees(3'b000);
    chk("d_free", 32'(bus.o_free), 32'h1);
    step();

    // Stray free while IDLE
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_frees(3'b100);
    step();
    set_frees(3'b000);
    chk("s_perr", 32'(o_proto_err), 32'h1);

`ifdef FORK_TIMEOUT_EN
    // Port 1 never frees; release forced 8 cycles after entering WAIT
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(32'h0000_0099);
    set_frees(3'b101);
    step();
    set_frees(3'b000);
    for (int k = 0; k <= 8; k++) begin
      chk("w_free", 32'(bus.o_free), 32'(k == 8));
      chk("w_tmo",  32'(o_timeout),  32'(k == 8));
      if (k < 8) step();
    end
    chk("w_perr_a", 32'(o_proto_err), 32'h0);
    step();
    set_frees(3'b010);
    step();
    set_frees(3'b000);
    chk("w_perr_b", 32'(o_proto_err), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
